// File: rtl/avionics_pkg.sv
// Shared constants for the host command receiver: sync byte,
// error codes and the receive FSM state encoding.
package avionics_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BADLEN  = 2'd1;
  localparam logic [1:0] ERR_BADSUM  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_HOLD
  } rx_state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter. Ports: clk, rst (async high), clear (byte
// strobe), enable (mid-frame), expired (count at TIMEOUT_CYCLES-1).
module rx_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/host_cmd_rx.sv
// Host command frame receiver: A5, cmd, len, payload, checksum.
// Ports: clk, rst, rx_data/new_rx_data in; cmd_* held frame with
// cmd_valid/cmd_ack handshake; cmd_err/err_code error strobe.
module host_cmd_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_LEN        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic [7:0]  cmd_id,
  output logic [3:0]  cmd_len,
  output logic [63:0] cmd_payload,
  output logic        cmd_err,
  output logic [1:0]  err_code
);

  import avionics_pkg::*;

  rx_state_t   st;
  logic [7:0]  cmd_q;
  logic [7:0]  sum;
  logic [3:0]  len;
  logic [3:0]  idx;
  logic [63:0] buf_q;
  logic        gap_en;
  logic        expired;

  assign gap_en = (st == ST_CMD) || (st == ST_LEN) ||
                  (st == ST_DATA) || (st == ST_CSUM);

  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clear  (new_rx_data),
    .enable (gap_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_SYNC;
      cmd_q       <= '0;
      sum         <= '0;
      len         <= '0;
      idx         <= '0;
      buf_q       <= '0;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      cmd_err     <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      cmd_err <= 1'b0;
      // a strobe on the expiry cycle wins over the timeout
      if (expired && !new_rx_data) begin
        cmd_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
        st       <= ST_SYNC;
      end else begin
        unique case (st)
          ST_SYNC: begin
            if (new_rx_data && rx_data == SYNC_BYTE) begin
              buf_q <= '0;
              st    <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (new_rx_data) begin
              cmd_q <= rx_data;
              sum   <= rx_data;
              st    <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (new_rx_data) begin
              if (rx_data > 8'(MAX_LEN)) begin
                cmd_err  <= 1'b1;
                err_code <= ERR_BADLEN;
                st       <= ST_SYNC;
              end else begin
                len <= rx_data[3:0];
                sum <= sum + rx_data;
                idx <= '0;
                st  <= (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (new_rx_data) begin
              buf_q[{idx[2:0], 3'b000} +: 8] <= rx_data;
              sum <= sum + rx_data;
              idx <= idx + 4'd1;
              if (idx == len - 4'd1) st <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (new_rx_data) begin
              if (rx_data == sum) begin
                cmd_id      <= cmd_q;
                cmd_len     <= len;
                cmd_payload <= buf_q;
                cmd_valid   <= 1'b1;
                st          <= ST_HOLD;
              end else begin
                cmd_err  <= 1'b1;
                err_code <= ERR_BADSUM;
                st       <= ST_SYNC;
              end
            end
          end
          ST_HOLD: begin
            if (new_rx_data) begin
              cmd_err  <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
            if (cmd_ack) begin
              cmd_valid <= 1'b0;
              st        <= ST_SYNC;
            end
          end
          default: st <= ST_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_rx.sv
// Scoreboard bench for host_cmd_rx: frames and errors expected
// by the stimulus tasks are matched by a negedge monitor.
module tb_host_cmd_rx;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        new_rx_data = 1'b0;
  logic        cmd_valid;
  logic        cmd_ack = 1'b0;
  logic [7:0]  cmd_id;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        cmd_err;
  logic [1:0]  err_code;

  typedef struct packed {
    logic [7:0]  id;
    logic [3:0]  len;
    logic [63:0] pl;
  } frame_t;

  frame_t     exp_q[$];
  logic [1:0] err_q[$];
  int n_pass = 0;
  int n_total = 0;
  logic valid_d = 1'b0;

  host_cmd_rx #(.TIMEOUT_CYCLES(T), .MAX_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .new_rx_data(new_rx_data),
    .cmd_valid  (cmd_valid),
    .cmd_ack    (cmd_ack),
    .cmd_id     (cmd_id),
    .cmd_len    (cmd_len),
    .cmd_payload(cmd_payload),
    .cmd_err    (cmd_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    frame_t f;
    logic [1:0] c;
    if (!rst) begin
      if (cmd_valid && !valid_d) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL frame: unexpected id=%h len=%0d", cmd_id, cmd_len);
        end else begin
          f = exp_q.pop_front();
          if ({cmd_id, cmd_len, cmd_payload} !== f) begin
            $display("FAIL frame: got %h/%0d/%h want %h/%0d/%h",
                     cmd_id, cmd_len, cmd_payload, f.id, f.len, f.pl);
          end else n_pass++;
        end
      end
      if (cmd_err) begin
        n_total++;
        if (err_q.size() == 0) begin
          $display("FAIL err: unexpected code=%0d", err_code);
        end else begin
          c = err_q.pop_front();
          if (err_code !== c) begin
            $display("FAIL err: code got %0d want %0d", err_code, c);
          end else n_pass++;
        end
      end
    end
    valid_d <= cmd_valid;
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %h want %h", nm, got, want);
    else n_pass++;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input int len,
                            input logic [63:0] pl, input logic push);
    logic [7:0] s;
    frame_t f;
    s = id + 8'(len);
    for (int i = 0; i < len; i++) s = s + pl[8*i +: 8];
    if (push) begin
      f.id = id;
      f.len = 4'(len);
      f.pl = pl;
      exp_q.push_back(f);
    end
    send(8'hA5);
    send(id);
    send(8'(len));
    for (int i = 0; i < len; i++) send(pl[8*i +: 8]);
    send(s);
  endtask

  task automatic ack();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("ack_release", {63'd0, cmd_valid}, 64'd0);
  endtask

  task automatic test_reset();
    idle(2);
    chk("rst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_err", {61'd0, cmd_err, err_code}, 64'd0);
    chk("rst_id_len", {52'd0, cmd_id, cmd_len}, 64'd0);
    chk("rst_payload", cmd_payload, 64'd0);
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    exp_q.push_back({8'h10, 4'd2, 64'h2211});
    send(8'hA5); send(8'h10); send(8'h02);
    send(8'h11); send(8'h22);
    chk("good_pre", {63'd0, cmd_valid}, 64'd0);
    send(8'h45);
    chk("good_valid", {63'd0, cmd_valid}, 64'd1);
    idle(3);
    chk("good_hold", {63'd0, cmd_valid}, 64'd1);
    ack();
  endtask

  task automatic test_max_then_zero();
    send_frame(8'h20, 8, 64'h0807060504030201, 1'b1);
    ack();
    send(8'h00);
    exp_q.push_back({8'h07, 4'd0, 64'd0});
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
    chk("zero_valid", {63'd0, cmd_valid}, 64'd1);
    chk("zero_payload", cmd_payload, 64'd0);
    ack();
    cmd_ack = 1'b1;
    idle(2);
    cmd_ack = 1'b0;
  endtask

  task automatic test_bad_frames();
    err_q.push_back(2'd1);
    send(8'hA5); send(8'h01); send(8'h09);
    chk("badlen_pulse", {63'd0, cmd_err}, 64'd1);
    idle(2);
    err_q.push_back(2'd2);
    send(8'hA5); send(8'h01); send(8'h01); send(8'hAA); send(8'h00);
    chk("badsum_pulse", {63'd0, cmd_err}, 64'd1);
    idle(1);
    chk("badsum_novalid", {63'd0, cmd_valid}, 64'd0);
    chk("badsum_id_kept", {56'd0, cmd_id}, 64'h07);
    chk("err_code_holds", {62'd0, err_code}, 64'd2);
  endtask

  task automatic test_timeout();
    send(8'hA5); send(8'h03);
    err_q.push_back(2'd3);
    idle(T - 1);
    chk("to_early", {63'd0, cmd_err}, 64'd0);
    idle(1);
    chk("to_fire", {63'd0, cmd_err}, 64'd1);
    idle(2);
    send_frame(8'h5A, 1, 64'h33, 1'b1);
    chk("to_recover", {63'd0, cmd_valid}, 64'd1);
    ack();
  endtask

  task automatic test_expiry_strobe();
    exp_q.push_back({8'h03, 4'd1, 64'h42});
    send(8'hA5); send(8'h03);
    idle(T - 1);
    send(8'h01);
    idle(T - 1);
    send(8'h42);
    idle(T - 1);
    send(8'h46);
    chk("exp_valid", {63'd0, cmd_valid}, 64'd1);
    ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h66, 3, 64'hCCBBAA, 1'b1);
    err_q.push_back(2'd3);
    send(8'h55);
    chk("ovr_pulse", {63'd0, cmd_err}, 64'd1);
    idle(2);
    chk("ovr_valid", {63'd0, cmd_valid}, 64'd1);
    chk("ovr_held", {cmd_id, cmd_len, cmd_payload[51:0]},
        {8'h66, 4'd3, 52'hCCBBAA});
    ack();
  endtask

  task automatic test_reset_mid();
    send(8'hA5); send(8'h10); send(8'h04); send(8'h11);
    rst = 1'b1;
    idle(1);
    chk("mid_zero", {cmd_id, cmd_len, 52'd0}, 64'd0);
    chk("mid_payload", cmd_payload, 64'd0);
    chk("mid_flags", {61'd0, cmd_valid, err_code}, 64'd0);
    rst = 1'b0;
    send_frame(8'h10, 4, 64'h44332211, 1'b1);
    ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h30, 1, 64'hA5, 1'b1);
    ack();
    send_frame(8'h31, 2, 64'hA5A5, 1'b1);
    ack();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_max_then_zero();
    test_bad_frames();
    test_timeout();
    test_expiry_strobe();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    idle(4);
    chk("sb_frames_left", 64'(exp_q.size()), 64'd0);
    chk("sb_errs_left", 64'(err_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
